// File: rtl/dev_arbiter_pkg.sv
// dev_arbiter_pkg: shared CPU/device definitions for the device-port arbiter
// Holds the arbiter state encoding (equal to the one-hot grant value) and the
// default downstream-busy abort threshold.
package dev_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;
   localparam int TIMEOUT_DEFAULT = 1024;
endpackage

// File: rtl/dev_arbiter.sv
// dev_arbiter: round-robin arbiter giving two masters access to one device port
// Ports: clk/rst (sync, active-high); mN_* master request side (enable, write,
// addr, dataSave, byteSelect in; dataLoad, busy out); dev* forwarded request
// and downstream response; grant_o one-hot owner (00 = idle); timeout_o one-cycle
// pulse when a stuck downstream transfer is forcibly aborted.
module dev_arbiter
   import dev_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_enable_i,
   input  logic        m0_write_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_dataSave_i,
   input  logic [3:0]  m0_byteSelect_i,
   output logic [31:0] m0_dataLoad_o,
   output logic        m0_busy_o,
   input  logic        m1_enable_i,
   input  logic        m1_write_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_dataSave_i,
   input  logic [3:0]  m1_byteSelect_i,
   output logic [31:0] m1_dataLoad_o,
   output logic        m1_busy_o,
   output logic        devEnable_o,
   output logic        devWrite_o,
   output logic [31:0] devPhysicalAddr_o,
   output logic [31:0] devDataSave_o,
   output logic [3:0]  devByteSelect_o,
   input  logic        devBusy_i,
   input  logic [31:0] devDataLoad_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
   state_t r_state, w_next, w_other;
   logic r_last;
   logic [CW-1:0] r_cnt;
   logic w_own0, w_own1, w_oen, w_oreq, w_tmo, w_den, w_done;
   // Ownership is masked by rst so the bus is released in the reset cycle itself.
   assign w_own0 = !rst && r_state == OWN0;
   assign w_own1 = !rst && r_state == OWN1;
   assign w_oen  = (w_own0 && m0_enable_i) || (w_own1 && m1_enable_i);
   assign w_oreq = (w_own0 && m1_enable_i) || (w_own1 && m0_enable_i);
   assign w_tmo  = w_oen && devBusy_i && r_cnt == CMAX;
   assign w_den  = w_oen && !w_tmo;
   assign w_done = w_oen && (!devBusy_i || w_tmo);
   assign w_other = r_state == OWN0 ? OWN1 : OWN0;
   assign devEnable_o       = w_den;
   assign devWrite_o        = w_own0 ? m0_write_i      : w_own1 ? m1_write_i      : 1'b0;
   assign devPhysicalAddr_o = w_own0 ? m0_addr_i       : w_own1 ? m1_addr_i       : '0;
   assign devDataSave_o     = w_own0 ? m0_dataSave_i   : w_own1 ? m1_dataSave_i   : '0;
   assign devByteSelect_o   = w_own0 ? m0_byteSelect_i : w_own1 ? m1_byteSelect_i : '0;
   assign m0_busy_o     = w_own0 ? devBusy_i && !w_tmo : 1'b1;
   assign m1_busy_o     = w_own1 ? devBusy_i && !w_tmo : 1'b1;
   assign m0_dataLoad_o = w_own0 && !w_tmo ? devDataLoad_i : '0;
   assign m1_dataLoad_o = w_own1 && !w_tmo ? devDataLoad_i : '0;
   assign grant_o   = rst ? 2'b00 : r_state;
   assign timeout_o = w_tmo;
   // r_last = 1 means m1 was served last, so m0 wins a tie.
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = (m0_enable_i && (!m1_enable_i || r_last)) ? OWN0 : m1_enable_i ? OWN1 : IDLE;
      else if (!w_oen || w_done)
         w_next = w_oreq ? w_other : w_oen ? r_state : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_done) r_last <= w_own1;
         r_cnt <= (w_den && devBusy_i) ? (r_cnt == CMAX ? CMAX : r_cnt + 1'b1) : '0;
      end
   end
endmodule

// File: doc/dev_arbiter.md
DEV_ARBITER -- requirements
Module: dev_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: consecutive downstream-busy cycles before a forced abort.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have, for each N in {0,1}, port mN_enable_i, input, 1: master N requests an access; held until completion.
REQ-005 SHALL have port mN_write_i, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have port mN_addr_i, input, 32: physical address.
REQ-007 SHALL have port mN_dataSave_i, input, 32: write data.
REQ-008 SHALL have port mN_byteSelect_i, input, 4: byte lanes.
REQ-009 SHALL have port mN_dataLoad_o, output, 32: read data, valid in the completion cycle.
REQ-010 SHALL have port mN_busy_o, output, 1: 1 = stall; enable high with busy low marks completion.
REQ-011 SHALL have ports devEnable_o/devWrite_o (1 each), devPhysicalAddr_o/devDataSave_o (32 each), devByteSelect_o (4), all outputs: the forwarded request.
REQ-012 SHALL have ports devBusy_i, input, 1, and devDataLoad_i, input, 32: downstream response.
REQ-013 SHALL have port grant_o, output, 2: one-hot current owner; 00 = IDLE.
REQ-014 SHALL have port timeout_o, output, 1: one-cycle pulse on forced abort.

Function
REQ-015 SHALL implement states IDLE, OWN0 and OWN1, with grant_o = 00/01/10 respectively.
REQ-016 In IDLE, every requesting master SHALL see busy_o=1, and devEnable_o SHALL be 0.
REQ-017 From IDLE, the winner SHALL be registered into OWNx next cycle: m0 only -> OWN0; m1 only -> OWN1; both -> the master not served last (reset value of last-served = m1, so m0 wins first).
REQ-018 In OWNx, dev* outputs SHALL equal master x inputs combinationally, mx_busy_o SHALL equal devBusy_i, and mx_dataLoad_o SHALL equal devDataLoad_i.
REQ-019 The non-owner SHALL see busy_o=1; the non-owner's dataLoad_o SHALL be 0.
REQ-020 Completion SHALL be the cycle in which the owner has enable=1 and devBusy_i=0; last-served SHALL update to the owner.
REQ-021 On completion, the next state SHALL be OWN(other) if the other master requests, else remain OWNx (parking), giving zero-overhead back-to-back access for a lone master.
REQ-022 If the owner's enable is 0 in OWNx, the next state SHALL be OWN(other) if the other master requests, else IDLE.
REQ-023 The timeout counter SHALL increment each OWNx cycle with devEnable_o=1 and devBusy_i=1, clear on any other cycle, and saturate at TIMEOUT-1.
REQ-024 When the counter equals TIMEOUT-1 and devBusy_i=1, that cycle SHALL force owner busy_o=0, owner dataLoad_o=0, devEnable_o=0 and timeout_o=1, and SHALL be treated as a completion per REQ-021.
REQ-025 Grant SHALL never change while the owner has enable=1 and no completion has occurred (no mid-transaction preemption).

Reset
REQ-026 While rst=1, state SHALL be IDLE, last-served = m1, counter = 0; grant_o, timeout_o and devEnable_o SHALL be 0, and both busy_o SHALL be 1.
REQ-027 Reset asserted mid-transaction SHALL abort it: devEnable_o drops in the same cycle, and the first post-reset cycle is IDLE.

Structure
REQ-028 The state encoding and default TIMEOUT constant SHALL live in the shared CPU/device package.
REQ-029 The round-robin pick, mux and counter SHALL stay inline; no sub-module.

Verification
REQ-030 m0 alone reads 0x80000000, downstream busy 2 cycles, then load 0xDEADBEEF -> grant 01 after 1 IDLE cycle; m0_busy_o falls with m0_dataLoad_o=0xDEADBEEF.
REQ-031 m0 and m1 request in the same IDLE cycle -> m0 served first, m1 granted the cycle after m0's completion, m0 then stalls.
REQ-032 m0 issues 4 back-to-back single-cycle writes with m1 idle -> grant stays 01; 4 completions in 4 cycles after the first grant.
REQ-033 devBusy_i stuck at 1 with TIMEOUT=8 -> on the 8th busy cycle timeout_o=1, m0_busy_o=0, m0_dataLoad_o=0; the next request is served normally.
REQ-034 rst pulsed during OWN1 with devBusy_i=1 -> devEnable_o=0 immediately, grant_o=00, and after release m0/m1 contention grants m0.
